// File: rtl/rv_pkg.sv
// Shared writeback types: register-file geometry, request bundle, source ids
// and the starvation-guard state encoding.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [0:0] {
        WB_SRC_EX  = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    typedef enum logic {
        FAVOR_MEM = 1'b0,
        FORCE_EX  = 1'b1
    } starve_state_e;

endpackage

// File: rtl/wb_prio_starve.sv
// Fixed-priority (memory first) writeback grant with a starvation guard that
// forces the execute source through after STARVE_LIMIT consecutive refusals.
module wb_prio_starve
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ex_valid,
    input  logic       mem_valid,
    output logic [1:0] grant
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    starve_state_e    state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             ex_gnt, mem_gnt;

    // Grant decision: memory wins a conflict unless execute is being forced; nothing while in reset
    always_comb begin
        ex_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!reset) begin
            if (ex_valid && mem_valid) begin
                ex_gnt  = (state_q == FORCE_EX);
                mem_gnt = (state_q != FORCE_EX);
            end else begin
                ex_gnt  = ex_valid;
                mem_gnt = mem_valid;
            end
        end
        grant                  = '0;
        grant[int'(WB_SRC_EX)]  = ex_gnt;
        grant[int'(WB_SRC_MEM)] = mem_gnt;
    end

    // Refusal counter and guard state: FORCE_EX exactly when the counter sits at the limit
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ex_valid || ex_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        state_d = (starve_cnt_d == LIMIT_C) ? FORCE_EX : FAVOR_MEM;
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FAVOR_MEM;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between execute and
// memory writeback, with one registered output stage and a conflict counter.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int PERF_W       = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    output logic                  ex_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_reg_write,
    output logic [PERF_W-1:0]     conflict_count
);

    logic [1:0]            grant;
    wb_req_t               sel_req;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_data_q, wb_data_d;
    logic                  wb_reg_write_q, wb_reg_write_d;
    logic [PERF_W-1:0]     conflict_count_q, conflict_count_d;

    wb_prio_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clock    (clock),
        .reset    (reset),
        .ex_valid (ex_valid),
        .mem_valid(mem_valid),
        .grant    (grant)
    );

    assign ex_ready  = grant[int'(WB_SRC_EX)];
    assign mem_ready = grant[int'(WB_SRC_MEM)];

    // Mux the granted request into the output stage; x0 writes are accepted but never enabled
    always_comb begin
        sel_req.rd   = mem_rd;
        sel_req.data = mem_data;
        if (grant[int'(WB_SRC_EX)]) begin
            sel_req.rd   = ex_rd;
            sel_req.data = ex_data;
        end
        transfer       = |grant;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_reg_write_d = 1'b0;
        if (transfer) begin
            wb_rd_d        = sel_req.rd;
            wb_data_d      = sel_req.data;
            wb_reg_write_d = (sel_req.rd != '0);
        end
    end

    // Saturating count of cycles where both sources competed
    always_comb begin
        conflict_count_d = conflict_count_q;
        if (ex_valid && mem_valid && (conflict_count_q != '1)) begin
            conflict_count_d = conflict_count_q + 1'b1;
        end
    end

    // Output stage and perf counter registers; reset drops any pending write
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            wb_reg_write_q   <= 1'b0;
            conflict_count_q <= '0;
        end else begin
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            wb_reg_write_q   <= wb_reg_write_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign wb_reg_write   = wb_reg_write_q;
    assign conflict_count = conflict_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a cycle-level
// reference model of the arbitration rules and a behavioural register file.
module tb_regfile_wb_arbiter;

    localparam int LIMIT  = 3;
    localparam int CC_MAX = 65535;
    localparam int CS_MAX = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  ex_rd = '0, mem_rd = '0;
    logic [31:0] ex_data = '0, mem_data = '0;

    logic        ex_ready, mem_ready, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] conflict_count;

    logic        s_ex_ready, s_mem_ready, s_wb_reg_write;
    logic [4:0]  s_wb_rd;
    logic [31:0] s_wb_data;
    logic [1:0]  s_conflict_count;

    always #5 clock = ~clock;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .PERF_W(16)) dut (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
        .conflict_count(conflict_count)
    );

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .PERF_W(2)) dut_s (
        .clock(clock), .reset(reset),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(s_ex_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(s_mem_ready),
        .wb_rd(s_wb_rd), .wb_data(s_wb_data), .wb_reg_write(s_wb_reg_write),
        .conflict_count(s_conflict_count)
    );

    // Behavioural register file committing on the falling edge
    logic [31:0] tb_rf  [32] = '{default: 32'h0};
    logic [31:0] exp_rf [32] = '{default: 32'h0};
    always @(negedge clock) begin
        if (wb_reg_write) tb_rf[wb_rd] <= wb_data;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (value expected after the most recent rising edge)
    bit          m_known = 1'b0;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_we;
    int          m_cc, m_cc_s, m_refused;
    bit          ex_acc = 1'b0, mem_acc = 1'b0;

    task automatic step(input bit rst,
                        input bit exv, input logic [4:0] exr, input logic [31:0] exd,
                        input bit memv, input logic [4:0] memr, input logic [31:0] memd);
        bit g_ex, g_mem;
        @(negedge clock);
        reset = rst; ex_valid = exv; ex_rd = exr; ex_data = exd;
        mem_valid = memv; mem_rd = memr; mem_data = memd;
        #1;
        if (m_known) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, m_data);
            chk("wb_reg_write", wb_reg_write, m_we);
            chk("conflict_count", conflict_count, m_cc);
            chk("conflict_count_sat", s_conflict_count, m_cc_s);
        end
        g_ex = 1'b0; g_mem = 1'b0;
        if (!rst) begin
            if (exv && memv) begin
                if (m_refused >= LIMIT) g_ex = 1'b1;
                else g_mem = 1'b1;
            end else begin
                g_ex = exv; g_mem = memv;
            end
        end
        chk("ex_ready", ex_ready, g_ex);
        chk("mem_ready", mem_ready, g_mem);
        if (rst) begin
            m_rd = '0; m_data = '0; m_we = 1'b0;
            m_cc = 0; m_cc_s = 0; m_refused = 0; m_known = 1'b1;
        end else begin
            if (g_ex || g_mem) begin
                m_rd   = g_ex ? exr : memr;
                m_data = g_ex ? exd : memd;
                m_we   = (m_rd != 0);
                if (m_we) exp_rf[m_rd] = m_data;
            end else begin
                m_we = 1'b0;
            end
            if (exv && memv) begin
                m_cc   = (m_cc < CC_MAX) ? m_cc + 1 : CC_MAX;
                m_cc_s = (m_cc_s < CS_MAX) ? m_cc_s + 1 : CS_MAX;
            end
            if (!exv || g_ex) m_refused = 0;
            else m_refused = (m_refused < LIMIT) ? m_refused + 1 : LIMIT;
        end
        ex_acc = g_ex; mem_acc = g_mem;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    bit          c_exv, c_memv, c_rst;
    logic [4:0]  c_exr, c_memr;
    logic [31:0] c_exd, c_memd;

    initial begin
        // Reset with both sources requesting, then idle
        step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        idle(2);
        chk("reset_cc", conflict_count, 32'd0);

        // Single execute request
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        idle(1);
        chk("single_rd", wb_rd, 32'd5);
        chk("single_data", wb_data, 32'hDEADBEEF);
        chk("single_we", wb_reg_write, 32'd1);
        idle(1);
        chk("single_we_drop", wb_reg_write, 32'd0);

        // Conflict: memory first, execute forced through after LIMIT refusals
        step(1'b0, 1'b1, 5'd8, 32'h22, 1'b1, 5'd7,  32'h11);
        step(1'b0, 1'b1, 5'd8, 32'h22, 1'b1, 5'd9,  32'h33);
        step(1'b0, 1'b1, 5'd8, 32'h22, 1'b1, 5'd10, 32'h44);
        step(1'b0, 1'b1, 5'd8, 32'h22, 1'b1, 5'd11, 32'h55);
        step(1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd11, 32'h55);
        chk("forced_ex_rd", wb_rd, 32'd8);
        chk("forced_ex_data", wb_data, 32'h22);
        idle(2);

        // Write to x0 is accepted then dropped
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        idle(1);
        chk("x0_we", wb_reg_write, 32'd0);

        // Back-to-back alternating sources
        step(1'b0, 1'b1, 5'd12, 32'hA0A0_0001, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hB0B0_0002);
        step(1'b0, 1'b1, 5'd14, 32'hA0A0_0003, 1'b0, 5'd0, 32'h0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hB0B0_0004);
        idle(2);

        // Saturation of the narrow counter
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'd16, 32'h16, 1'b1, 5'd17, 32'h17);
        idle(1);
        chk("sat_narrow", s_conflict_count, 32'd3);
        chk("sat_wide", conflict_count, 32'd5);

        // Reset the cycle after a grant; guard must restart from zero
        step(1'b0, 1'b1, 5'd3, 32'h0000_000A, 1'b0, 5'd0, 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        idle(1);
        chk("reset_drop_we", wb_reg_write, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'd18, 32'h18, 1'b1, 5'd19, 32'h19);
        idle(2);

        // Randomized traffic honoring the hold-while-refused rule
        c_exv = 1'b0; c_memv = 1'b0; ex_acc = 1'b0; mem_acc = 1'b0;
        c_exr = '0; c_memr = '0; c_exd = '0; c_memd = '0;
        for (int i = 0; i < 2000; i++) begin
            c_rst = ($urandom_range(0, 59) == 0);
            if (!(c_exv && !ex_acc)) begin
                c_exv = ($urandom_range(0, 2) != 0);
                c_exr = 5'($urandom_range(0, 31));
                c_exd = $urandom;
            end
            if (!(c_memv && !mem_acc)) begin
                c_memv = ($urandom_range(0, 2) != 0);
                c_memr = 5'($urandom_range(0, 31));
                c_memd = $urandom;
            end
            step(c_rst, c_exv, c_exr, c_exd, c_memv, c_memr, c_memd);
        end
        idle(3);

        // Register file contents must match every committed write
        for (int r = 0; r < 32; r++) chk($sformatf("rf_x%0d", r), tb_rf[r], exp_rf[r]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
